// File: rtl/lsu_data_mem.sv
// rtl/lsu_data_mem.sv - RV32I load/store data memory with fixed read latency and one outstanding request
module lsu_data_mem #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // BUSY lasts READ_LAT-1 cycles; the counter runs down to zero inclusive.
    localparam logic [1:0]      CNT_INIT   = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DEPTH);

    logic [1:0]      state;
    logic [1:0]      cnt;
    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   pend_idx;
    logic [1:0]      pend_off;
    logic [2:0]      pend_f3;

    logic            accept;
    logic            req_err;
    logic [AW-1:0]   req_idx;
    logic [1:0]      req_off;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid && req_ready;
    assign req_idx    = req_addr[AW+1:2];
    assign req_off    = req_addr[1:0];

    // Classify the presented request: bad width code, out of range, misaligned, or unsigned store.
    always_comb begin
        logic f3_bad;
        logic range_bad;
        logic misal;
        logic st_bad;
        f3_bad    = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        range_bad = (req_addr >= ADDR_LIMIT);
        misal     = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                    ((req_funct3 == 3'b010) && (req_off != 2'b00));
        st_bad    = req_write && req_funct3[2];
        req_err   = f3_bad || range_bad || misal || st_bad;
    end

    // Select the addressed byte/halfword and extend it according to the width code.
    function automatic logic [XLEN-1:0] shape(input logic [XLEN-1:0] w,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  shape = {{(XLEN-8){b[7]}}, b};
            3'b100:  shape = {{(XLEN-8){1'b0}}, b};
            3'b001:  shape = {{(XLEN-16){h[15]}}, h};
            3'b101:  shape = {{(XLEN-16){1'b0}}, h};
            default: shape = w;
        endcase
    endfunction

    // Storage: cleared on reset, stores land at the acceptance edge with lane masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && req_write && !req_err) begin
            case (req_funct3[1:0])
                2'b00:   mem[req_idx][{req_off, 3'b000} +: 8]        <= req_wdata[7:0];
                2'b01:   mem[req_idx][{req_off[1], 4'b0000} +: 16]   <= req_wdata[15:0];
                default: mem[req_idx]                                <= req_wdata;
            endcase
        end
    end

    // Request/response sequencing and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            pend_idx   <= '0;
            pend_off   <= 2'd0;
            pend_f3    <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= S_RESP;
                        end else if (req_write) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                            state      <= S_RESP;
                        end else if (READ_LAT == 1) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= shape(mem[req_idx], req_funct3, req_off);
                            state      <= S_RESP;
                        end else begin
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                            pend_idx   <= req_idx;
                            pend_off   <= req_off;
                            pend_f3    <= req_funct3;
                            cnt        <= CNT_INIT;
                            state      <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == 2'd0) begin
                        resp_rdata <= shape(mem[pend_idx], pend_f3, pend_off);
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb/tb_lsu_data_mem.sv - self-checking bench for lsu_data_mem
module tb_lsu_data_mem;

    typedef struct {
        string       name;
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        s_reset;
    logic        s_req_valid;
    logic        s_req_write;
    logic [2:0]  s_req_funct3;
    logic [31:0] s_req_addr;
    logic [31:0] s_req_wdata;
    logic        s_resp_ready;
    logic [3:0]  s_req_ready;
    logic [3:0]  s_resp_valid;
    logic [3:0]  s_resp_err;
    logic [31:0] s_resp_rdata [4];

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    lsu_data_mem #(.XLEN(32), .DEPTH(64), .READ_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lat
        lsu_data_mem #(.XLEN(32), .DEPTH(64), .READ_LAT(g + 1)) u_s (
            .clk(clk), .reset(s_reset),
            .req_valid(s_req_valid), .req_ready(s_req_ready[g]), .req_write(s_req_write),
            .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
            .resp_valid(s_resp_valid[g]), .resp_ready(s_resp_ready),
            .resp_rdata(s_resp_rdata[g]), .resp_err(s_resp_err[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string name, input logic w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic e);
        vec_t v;
        v.name = name; v.write = w; v.f3 = f3; v.addr = a;
        v.wdata = wd; v.rdata = rd; v.err = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        req_valid  = 1'b1;
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.name  = v.name;
        e.rdata = v.rdata;
        e.err   = v.err;
        e.lat   = (v.write || v.err) ? 1 : 2;
        sb.push_back(e);
    endtask

    // Called at the first negedge after the acceptance edge; counts cycles to resp_valid.
    task automatic wait_and_compare();
        int   cyc;
        bit   got;
        exp_t e;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 20) begin
            if (resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no resp_valid within 20 cycles, required latency %0d", e.name, e.lat);
        end else begin
            check({e.name, "_lat"},   32'(cyc), 32'(e.lat));
            check({e.name, "_rdata"}, resp_rdata, e.rdata);
            check({e.name, "_err"},   {31'd0, resp_err}, {31'd0, e.err});
        end
    endtask

    task automatic run_vec(input vec_t v);
        check({v.name, "_ready"}, {31'd0, req_ready}, 32'd1);
        drive(v);
        @(negedge clk);
        req_valid = 1'b0;
        wait_and_compare();
        @(negedge clk);
        check({v.name, "_done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        s_reset = 1'b1; s_req_valid = 1'b0; s_req_write = 1'b0; s_req_funct3 = 3'd0;
        s_req_addr = '0; s_req_wdata = '0; s_resp_ready = 1'b1;

        vt.push_back(mk("sw_10",      1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk("lw_10",      0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk("sb_11",      1, 3'b000, 32'h11, 32'h0000005A, 32'h0,        0));
        vt.push_back(mk("lb_11",      0, 3'b000, 32'h11, 32'h0,        32'h0000005A, 0));
        vt.push_back(mk("lbu_13",     0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0));
        vt.push_back(mk("lh_12",      0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0));
        vt.push_back(mk("lhu_12",     0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 0));
        vt.push_back(mk("lw_10_b",    0, 3'b010, 32'h10, 32'h0,        32'hDEAD5AEF, 0));
        vt.push_back(mk("lw_12_mis",  0, 3'b010, 32'h12, 32'h0,        32'h0,        1));
        vt.push_back(mk("sh_101",     1, 3'b001, 32'h101, 32'hFFFF,    32'h0,        1));
        vt.push_back(mk("sh_11_mis",  1, 3'b001, 32'h11, 32'hFFFF,     32'h0,        1));
        vt.push_back(mk("lw_100",     0, 3'b010, 32'h100, 32'h0,       32'h0,        1));
        vt.push_back(mk("f3_011",     0, 3'b011, 32'h10, 32'h0,        32'h0,        1));
        vt.push_back(mk("sbu_store",  1, 3'b100, 32'h10, 32'h0,        32'h0,        1));
        vt.push_back(mk("f3_110",     0, 3'b110, 32'h10, 32'h0,        32'h0,        1));
        vt.push_back(mk("f3_111_st",  1, 3'b111, 32'h10, 32'h0,        32'h0,        1));
        vt.push_back(mk("lw_huge",    0, 3'b010, 32'hFFFFFFFC, 32'h0,  32'h0,        1));
        vt.push_back(mk("lw_10_keep", 0, 3'b010, 32'h10, 32'h0,        32'hDEAD5AEF, 0));
        vt.push_back(mk("sh_16",      1, 3'b001, 32'h16, 32'h1234ABCD, 32'h0,        0));
        vt.push_back(mk("lw_14",      0, 3'b010, 32'h14, 32'h0,        32'hABCD0000, 0));
        vt.push_back(mk("lh_16",      0, 3'b001, 32'h16, 32'h0,        32'hFFFFABCD, 0));
        vt.push_back(mk("lb_17",      0, 3'b000, 32'h17, 32'h0,        32'hFFFFFFAB, 0));
        vt.push_back(mk("lw_fc_zero", 0, 3'b010, 32'hFC, 32'h0,        32'h0,        0));
        vt.push_back(mk("sw_fc",      1, 3'b010, 32'hFC, 32'h80000001, 32'h0,        0));
        vt.push_back(mk("lw_fc",      0, 3'b010, 32'hFC, 32'h0,        32'h80000001, 0));
        vt.push_back(mk("lbu_fc",     0, 3'b100, 32'hFC, 32'h0,        32'h00000001, 0));
        vt.push_back(mk("lb_ff",      0, 3'b000, 32'hFF, 32'h0,        32'hFFFFFF80, 0));

        repeat (2) @(negedge clk);
        reset = 1'b0;
        s_reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);

        foreach (vt[i]) run_vec(vt[i]);

        // Backpressure: hold the load response, keep another load queued behind it.
        resp_ready = 1'b0;
        drive(mk("bp_lw_10", 0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 0));
        @(negedge clk);
        req_addr = 32'h14;
        wait_and_compare();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'hDEAD5AEF);
            check("bp_err",   {31'd0, resp_err}, 32'd0);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        drive(mk("bp_lw_14", 0, 3'b010, 32'h14, 32'h0, 32'hABCD0000, 0));
        @(negedge clk);
        check("bp_hs_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_hs_ready", {31'd0, req_ready},  32'd1);
        @(negedge clk);
        check("bp_accepted", {31'd0, req_ready},  32'd0);
        req_valid = 1'b0;
        wait_and_compare();
        @(negedge clk);

        // Reset coincident with a store: the store is dropped and memory is cleared.
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h12345678;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        check("rst_st_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_st_ready", {31'd0, req_ready},  32'd1);
        run_vec(mk("lw_10_after_rst", 0, 3'b010, 32'h10, 32'h0, 32'h0, 0));
        run_vec(mk("lw_fc_after_rst", 0, 3'b010, 32'hFC, 32'h0, 32'h0, 0));

        // READ_LAT=4 instance: reset while a load is in flight.
        s_req_valid = 1'b1; s_req_write = 1'b1; s_req_funct3 = 3'b010;
        s_req_addr = 32'h20; s_req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        s_req_valid = 1'b0;
        @(negedge clk);
        s_req_valid = 1'b1; s_req_write = 1'b0;
        @(negedge clk);
        s_req_valid = 1'b0;
        s_reset = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
        check("l4_rst_ready", {31'd0, s_req_ready[3]}, 32'd1);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (s_resp_valid[3]) seen = 1'b1;
                @(negedge clk);
            end
            check("l4_no_resp", {31'd0, seen}, 32'd0);
        end
        begin
            int cyc;
            bit got;
            s_req_valid = 1'b1;
            @(negedge clk);
            s_req_valid = 1'b0;
            cyc = 1;
            got = 1'b0;
            while (!got && cyc <= 20) begin
                if (s_resp_valid[3]) got = 1'b1;
                else begin
                    @(negedge clk);
                    cyc++;
                end
            end
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL l4_reload_timeout: no resp_valid within 20 cycles, required latency 4");
            end else begin
                check("l4_reload_lat",   32'(cyc), 32'd4);
                check("l4_reload_rdata", s_resp_rdata[3], 32'd0);
            end
            repeat (3) @(negedge clk);
        end

        // Back-to-back loads on all latencies with resp_ready held high.
        begin
            int last [4];
            int nacc [4];
            for (int g = 0; g < 4; g++) begin
                last[g] = -1;
                nacc[g] = 0;
            end
            s_req_valid = 1'b1; s_req_write = 1'b0; s_req_funct3 = 3'b010; s_req_addr = 32'h20;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                for (int g = 0; g < 4; g++) begin
                    if (s_req_ready[g]) begin
                        if (last[g] >= 0) check($sformatf("sweep_l%0d_spacing", g + 1), 32'(c - last[g]), 32'(g + 2));
                        last[g] = c;
                        nacc[g]++;
                    end
                end
            end
            s_req_valid = 1'b0;
            for (int g = 0; g < 4; g++) begin
                check($sformatf("sweep_l%0d_enough", g + 1), {31'd0, nacc[g] >= 5}, 32'd1);
            end
        end

        repeat (6) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, data and address width (32 only).
- DEPTH, default 64, word count (power of two, 4..1024).
- READ_LAT, default 2, cycles from read acceptance to resp_valid (1..4).

REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  load result; 0 for stores and errors.
- resp_err  out  1  request rejected.

REQ-003 The clock SHALL be clk and the reset SHALL be reset; reset is synchronous and active-high, with a single clock domain.

Function
REQ-004 The FSM SHALL have three states:
- IDLE: req_ready=1.
- BUSY: read latency count.
- RESP: resp_valid=1.
req_ready SHALL be 1 only in IDLE, so at most one request is outstanding.

REQ-005 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; request inputs are sampled only at that edge.

REQ-006 Error detection SHALL evaluate each accepted request for these conditions:
- req_addr >= 4*DEPTH;
- misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0;
- funct3 outside {000,001,010,100,101};
- a store with funct3 100 or 101.

REQ-007 Errored requests SHALL leave memory unchanged, go IDLE->RESP, and present resp_err=1 and resp_rdata=0 on the next cycle.

REQ-008 A valid store SHALL write memory at the acceptance edge:
- SB writes byte lane addr[1:0] from wdata[7:0].
- SH writes the halfword at addr[1] from wdata[15:0].
- SW writes the full word.
- Unselected lanes are preserved.
The FSM SHALL go IDLE->RESP with resp_err=0 and resp_rdata=0.

REQ-009 A valid load SHALL assert resp_valid exactly READ_LAT cycles after the acceptance edge.
- READ_LAT=1: IDLE->RESP directly.
- Otherwise: IDLE->BUSY, with a counter held for READ_LAT-1 cycles, then RESP.

REQ-010 Load data SHALL be shaped as follows:
- LB/LH: sign-extend the selected byte or halfword.
- LBU/LHU: zero-extend it.
- LW: return the word unchanged.

REQ-011 The word index SHALL be addr[log2(DEPTH)+1:2]; addresses SHALL never wrap modulo depth, since out-of-range addresses are errors per REQ-006.

REQ-012 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until an edge with resp_ready=1; the FSM then goes to IDLE, and resp_valid is 0 the following cycle.

REQ-013 A new request SHALL NOT be accepted in the same cycle as a response handshake; the minimum spacing between acceptances SHALL be 2 cycles for stores/errors and READ_LAT+1 cycles for loads.

REQ-014 When req_valid=0 in IDLE, no state change SHALL occur and memory SHALL hold.

REQ-015 Outputs SHALL be fully registered; there is no combinational path from req_* to resp_*.

Reset
REQ-016 When reset=1 at a rising edge, the block SHALL:
- enter IDLE;
- clear the latency counter;
- set resp_valid=0, resp_err=0, resp_rdata=0 and req_ready=1 from the next cycle;
- zero all DEPTH words.

REQ-017 Reset SHALL take priority over any request or response handshake in the same cycle; a request in flight during reset SHALL be dropped with no response, and a store accepted in the same cycle as reset SHALL NOT take effect.

Verification
REQ-018 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with READ_LAT=2 -> store response 1 cycle after accept with err=0 and rdata=0; load resp_valid exactly 2 cycles after accept with rdata=0xDEADBEEF.

REQ-019 After REQ-018, issue SB 0x11 data 0x5A, then LB 0x11, LBU 0x13, LH 0x12 and LHU 0x12 -> rdata 0x0000005A, 0x000000DE, 0xFFFFDEAD and 0x0000DEAD respectively (word = 0xDEAD5AEF).

REQ-020 Error cases:
- LW 0x12 -> err=1, rdata=0.
- SH 0x101 -> err=1, memory unchanged.
- LW 0x100 (DEPTH=64) -> err=1.
- funct3=011 -> err=1.
- SB with funct3=100 -> err=1.

REQ-021 Backpressure: hold resp_ready=0 for 5 cycles during a load response -> resp_valid, rdata and err stay stable, req_ready stays 0 and a queued req_valid is not accepted; after resp_ready=1, the request is accepted 2 edges later.

REQ-022 Assert reset 1 cycle after accepting an LW with READ_LAT=4 -> no resp_valid ever appears for that load, req_ready=1 after reset, and a subsequent LW of any address returns 0.

REQ-023 Sweep READ_LAT over 1..4 with back-to-back loads -> acceptance spacing is exactly READ_LAT+1 cycles with resp_ready held at 1.
